// File: rtl/serial_tx.sv
// rtl/serial_tx.sv - framed serial transmitter: start bit, WIDTH data bits LSB first, optional even parity, stop bit
module serial_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Data_in,
  input  logic             Load,
  output logic             Tx,
  output logic             Busy,
  output logic             Done
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state;
  logic [7:0]       bit_cnt;
  logic [IDX_W-1:0] bit_idx;
  logic [WIDTH-1:0] shreg;
  logic             par;
  logic             last_tick;
  logic [WIDTH-1:0] shreg_next;

  // End of the current bit period; also the point where the line changes level
  assign last_tick  = (bit_cnt == 8'(CLKS_PER_BIT - 1));
  assign shreg_next = shreg >> 1;

  // Frame sequencer; Tx/Busy/Done are all assigned here so they are registered
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      Tx      <= 1'b1;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      bit_cnt <= 8'd0;
      bit_idx <= '0;
      shreg   <= '0;
      par     <= 1'b0;
    end else begin
      Done <= 1'b0;
      if (state != IDLE) begin
        bit_cnt <= last_tick ? 8'd0 : bit_cnt + 8'd1;
      end
      case (state)
        IDLE: begin
          bit_cnt <= 8'd0;
          Tx      <= 1'b1;
          Busy    <= 1'b0;
          if (Load) begin
            // Parity is taken from the captured word, so later Data_in changes cannot leak in
            shreg   <= Data_in;
            par     <= ^Data_in;
            bit_idx <= '0;
            state   <= START;
            Tx      <= 1'b0;
            Busy    <= 1'b1;
          end
        end
        START: begin
          if (last_tick) begin
            state <= DATA;
            Tx    <= shreg[0];
          end
        end
        DATA: begin
          if (last_tick) begin
            if (bit_idx == IDX_W'(WIDTH - 1)) begin
              if (PARITY_EN != 0) begin
                state <= PARITY;
                Tx    <= par;
              end else begin
                state <= STOP;
                Tx    <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
              shreg   <= shreg_next;
              Tx      <= shreg_next[0];
            end
          end
        end
        PARITY: begin
          if (last_tick) begin
            state <= STOP;
            Tx    <= 1'b1;
          end
        end
        STOP: begin
          if (last_tick) begin
            // Done lands on the first IDLE cycle, where a new Load is already accepted
            state <= IDLE;
            Tx    <= 1'b1;
            Busy  <= 1'b0;
            Done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          Tx    <= 1'b1;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
